// File: rtl/mem_stage_dmem_ctrl.sv
// Memory-stage data-memory controller: issues a held load/store handshake,
// stalls upstream until the response, and registers extended load data for MEM/WB.
module mem_stage_dmem_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_read,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_funct3,
  input  logic [3:0]      req_load_sel,
  input  logic [4:0]      req_rd,
  output logic            dmem_read,
  output logic            dmem_write,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_mbe,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_resp,
  output logic            mem_stall,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_addr,
  output logic [XLEN-1:0] wb_load_data,
  output logic            wb_misaligned
);

  localparam logic [3:0] SEL_LW  = 4'b0011;
  localparam logic [3:0] SEL_LB  = 4'b0101;
  localparam logic [3:0] SEL_LBU = 4'b0110;
  localparam logic [3:0] SEL_LH  = 4'b0111;
  localparam logic [3:0] SEL_LHU = 4'b1000;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic            is_store, is_mem, misaligned, acc;
  logic            width_byte, width_half;
  logic [1:0]      off;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_mbe;

  logic [4:0]      rd_q;
  logic [XLEN-1:0] addr_q;
  logic [3:0]      sel_q;
  logic [1:0]      off_q;
  logic            load_q;
  logic [XLEN-1:0] ld_shift, ld_data;

  // Access decode; a store wins when read and write are both asserted.
  always_comb begin
    is_store   = req_write;
    is_mem     = req_read | req_write;
    off        = req_addr[1:0];
    width_byte = 1'b0;
    width_half = 1'b0;
    if (is_store) begin
      case (req_funct3)
        3'b000:  width_byte = 1'b1;
        3'b001:  width_half = 1'b1;
        default: ;
      endcase
    end else begin
      case (req_load_sel)
        SEL_LB, SEL_LBU: width_byte = 1'b1;
        SEL_LH, SEL_LHU: width_half = 1'b1;
        default:         ;
      endcase
    end
    if (width_byte)      misaligned = 1'b0;
    else if (width_half) misaligned = is_mem & off[0];
    else                 misaligned = is_mem & (off != 2'b00);
    acc = req_valid & is_mem & ~misaligned;

    if (width_byte) begin
      st_wdata = {4{req_wdata[7:0]}};
      st_mbe   = 4'b0001 << off;
    end else if (width_half) begin
      st_wdata = {2{req_wdata[15:0]}};
      st_mbe   = 4'b0011 << off;
    end else begin
      st_wdata = req_wdata;
      st_mbe   = 4'b1111;
    end
  end

  always_comb begin
    ld_shift = dmem_rdata >> {off_q, 3'b000};
    case (sel_q)
      SEL_LB:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      SEL_LBU: ld_data = {24'b0, ld_shift[7:0]};
      SEL_LH:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      SEL_LHU: ld_data = {16'b0, ld_shift[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        mem_stall = acc;
        if (acc) state_d = WAIT;
      end
      WAIT: begin
        mem_stall = ~dmem_resp;
        if (dmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      dmem_read     <= 1'b0;
      dmem_write    <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_mbe      <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_addr       <= '0;
      wb_load_data  <= '0;
      wb_misaligned <= 1'b0;
      rd_q          <= '0;
      addr_q        <= '0;
      sel_q         <= '0;
      off_q         <= '0;
      load_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          wb_valid      <= req_valid & ~acc;
          wb_misaligned <= req_valid & misaligned;
          if (req_valid & ~acc) begin
            wb_rd        <= req_rd;
            wb_addr      <= req_addr;
            wb_load_data <= '0;
          end
          if (acc) begin
            dmem_addr  <= {req_addr[XLEN-1:2], 2'b00};
            dmem_read  <= ~is_store;
            dmem_write <= is_store;
            dmem_wdata <= is_store ? st_wdata : '0;
            dmem_mbe   <= is_store ? st_mbe : 4'b0000;
            rd_q       <= req_rd;
            addr_q     <= req_addr;
            sel_q      <= req_load_sel;
            off_q      <= off;
            load_q     <= ~is_store;
          end
        end
        WAIT: begin
          wb_valid      <= dmem_resp;
          wb_misaligned <= 1'b0;
          if (dmem_resp) begin
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            wb_rd        <= rd_q;
            wb_addr      <= addr_q;
            wb_load_data <= load_q ? ld_data : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_stage_dmem_ctrl.md
Name: mem_stage_dmem_ctrl

Overview:
- Memory-stage controller between the EX/MEM pipeline register and the MEM/WB register of the RV32I pipeline.
- Turns load/store requests into a held data-memory handshake, generating byte enables and shifted store data.
- Stalls the pipeline until the memory responds.
- Registers sign/zero-extended load data for the writeback mux, keyed by the regfilemux load selects (lw/lb/lbu/lh/lhu).

Parameters:
XLEN, 32, datapath and address width; only 32 is supported.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  EX/MEM holds a valid instruction.
req_read  in  1  instruction is a load.
req_write  in  1  instruction is a store.
req_addr  in  32  effective address (ALU result).
req_wdata  in  32  store data (forwarded rs2).
req_funct3  in  3  store width: 000 sb, 001 sh, 010 sw.
req_load_sel  in  4  regfilemux select: 0011 lw, 0101 lb, 0110 lbu, 0111 lh, 1000 lhu.
req_rd  in  5  destination register.
dmem_read  out  1  memory read request.
dmem_write  out  1  memory write request.
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
dmem_wdata  out  32  lane-shifted store data.
dmem_mbe  out  4  byte enables.
dmem_rdata  in  32  read data; valid when dmem_resp=1.
dmem_resp  in  1  one-cycle completion pulse.
mem_stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
wb_valid  out  1  MEM/WB entry valid.
wb_rd  out  5  registered destination register.
wb_addr  out  32  registered req_addr, passed through for the alu_out writeback path.
wb_load_data  out  32  aligned, extended load result.
wb_misaligned  out  1  access was misaligned and suppressed.

Behaviour:
- Reset:
  - State IDLE.
  - dmem_read, dmem_write, dmem_mbe, wb_valid and wb_misaligned are 0.
  - dmem_addr, dmem_wdata, wb_rd, wb_addr and wb_load_data are 0.
- FSM states: IDLE, WAIT.
- Access definition: acc = req_valid & (req_read | req_write) & ~misaligned.
  - If req_read and req_write are both high, the access is a store.
- Misalignment rules:
  - Word access (lw/sw) is misaligned when addr[1:0] != 0.
  - Half access (lh/lhu/sh) is misaligned when addr[0] != 0.
  - Byte access is never misaligned.
- IDLE with acc=1:
  - mem_stall=1.
  - On the clock edge, register dmem_addr/wdata/mbe, set dmem_read or dmem_write, latch rd/addr/load_sel/offset, and go to WAIT.
- WAIT:
  - dmem_* are held constant.
  - mem_stall = ~dmem_resp.
  - On dmem_resp=1: drop dmem_read/write, load the MEM/WB outputs with wb_valid=1, return to IDLE.
  - Upstream advances on that same edge.
- Minimum latency: 2 cycles (request cycle plus response cycle). Each extra cycle without dmem_resp adds one stall cycle.
- Non-memory valid instruction in IDLE:
  - No stall.
  - Next edge: wb_valid=1, wb_rd/wb_addr loaded, wb_load_data=0.
- Misaligned load/store:
  - No dmem request and no stall.
  - Next edge: wb_valid=1, wb_misaligned=1, wb_load_data=0.
- req_valid=0 in IDLE: wb_valid=0 next edge.
- Store data shifting, with off = addr[1:0]:
  - sb: wdata = {4{req_wdata[7:0]}}, mbe = 4'b0001 << off.
  - sh: wdata = {2{req_wdata[15:0]}}, mbe = 4'b0011 << off.
  - sw: wdata = req_wdata, mbe = 4'b1111.
- Load data extraction, with sh = dmem_rdata >> (8*off):
  - lb: sign-extend sh[7:0].
  - lbu: zero-extend sh[7:0].
  - lh: sign-extend sh[15:0].
  - lhu: zero-extend sh[15:0].
  - lw: dmem_rdata.
- Store completion: wb_load_data=0, wb_valid=1.
- dmem_resp in IDLE is ignored.
- rst in WAIT:
  - Abandon the access and return to IDLE.
  - dmem_read/write are 0 after that edge.
  - A late dmem_resp is ignored.
- While in WAIT, req_* inputs are ignored; they are held anyway because mem_stall=1.

Test Plan:
- lb at 0x0000_1003, dmem_rdata=0x80FF_1234, resp 1 cycle after issue -> dmem_addr=0x0000_1000, mbe=0000 for read, wb_load_data=0xFFFF_FF80, mem_stall high exactly 1 cycle.
- lhu at 0x0000_1002, same rdata -> wb_load_data=0x0000_80FF; lh at 0x0000_1000 -> 0x0000_1234.
- sb at 0x0000_2001, req_wdata=0x0000_00AB -> dmem_write=1, dmem_addr=0x0000_2000, mbe=0010, dmem_wdata=0xABAB_ABAB; sw at 0x2000 -> mbe=1111.
- lw at 0x0000_3000, resp delayed 3 cycles -> mem_stall high 4 consecutive cycles, dmem_* stable throughout, wb_valid pulses once.
- lw at 0x0000_1001 -> no dmem_read, mem_stall never high, wb_misaligned=1, wb_valid=1.
- rst asserted during WAIT, then dmem_resp next cycle -> dmem_read=0 after reset edge, wb_valid stays 0, state IDLE.
